// File: rtl/gpioemu_bus_master.sv
// Strobe-bus initiator for the GPIO emulator peripheral: timed setup/strobe/hold
// transactions for host commands plus an optional autonomous INT poll-and-clear.
module gpioemu_bus_master #(
  parameter int          SETUP_CYC    = 2,
  parameter int          STROBE_CYC   = 4,
  parameter int          HOLD_CYC     = 2,
  parameter int          POLL_PERIOD  = 1000,
  parameter logic [15:0] INT_ADDR     = 16'h0178,
  parameter logic [15:0] INT_CLR_ADDR = 16'h017C,
  parameter int          INT_BIT      = 6
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  input  logic        poll_en,
  output logic        irq_pulse,
  output logic        busy,
  output logic [1:0]  dbg_state,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int          PW           = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_PERIOD - 1);
  localparam logic [15:0] SETUP_LAST   = 16'(SETUP_CYC - 1);
  localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYC - 1);
  localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYC - 1);
  localparam logic [31:0] INT_CLR_DATA = 32'd1 << INT_BIT;

  state_t        state;
  logic [15:0]   phase;
  logic [PW-1:0] poll_cnt;
  logic          poll_pending;
  logic          is_write;
  logic          is_poll;
  logic [31:0]   rd_cap;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // a pending poll request blocks acceptance so it always wins arbitration in IDLE.
  assign cmd_ready = (state == ST_IDLE) && !poll_pending;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= ST_IDLE;
      phase        <= '0;
      poll_cnt     <= POLL_RELOAD;
      poll_pending <= 1'b0;
      is_write     <= 1'b0;
      is_poll      <= 1'b0;
      rd_cap       <= '0;
      saddress     <= '0;
      sdata_wr     <= '0;
      srd          <= 1'b1;
      swr          <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      irq_pulse    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      irq_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          phase <= '0;
          if (poll_pending) begin
            state        <= ST_SETUP;
            poll_pending <= 1'b0;
            is_poll      <= 1'b1;
            is_write     <= 1'b0;
            saddress     <= INT_ADDR;
            sdata_wr     <= '0;
          end else if (cmd_valid) begin
            state    <= ST_SETUP;
            is_poll  <= 1'b0;
            is_write <= cmd_write;
            saddress <= cmd_addr;
            sdata_wr <= cmd_write ? cmd_wdata : 32'h0;
          end
        end
        ST_SETUP: begin
          if (phase == SETUP_LAST) begin
            state <= ST_STROBE;
            phase <= '0;
            srd   <= is_write;
            swr   <= !is_write;
          end else begin
            phase <= phase + 16'd1;
          end
        end
        ST_STROBE: begin
          if (phase == STROBE_LAST) begin
            state <= ST_HOLD;
            phase <= '0;
            srd   <= 1'b1;
            swr   <= 1'b1;
            // Read data is taken on the same edge the strobe is released.
            if (!is_write) rd_cap <= sdata_rd;
          end else begin
            phase <= phase + 16'd1;
          end
        end
        ST_HOLD: begin
          if (phase == HOLD_LAST) begin
            phase <= '0;
            if (is_poll && !is_write && rd_cap[INT_BIT]) begin
              state    <= ST_SETUP;
              is_write <= 1'b1;
              saddress <= INT_CLR_ADDR;
              sdata_wr <= INT_CLR_DATA;
            end else begin
              state <= ST_IDLE;
              if (is_poll) begin
                irq_pulse <= is_write;
              end else begin
                rsp_valid <= 1'b1;
                rsp_rdata <= is_write ? 32'h0 : rd_cap;
              end
            end
          end else begin
            phase <= phase + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed after the FSM so a new poll request overrides the clear on poll start.
      if (!poll_en) begin
        poll_cnt     <= POLL_RELOAD;
        poll_pending <= 1'b0;
      end else if (poll_cnt == '0) begin
        poll_cnt     <= POLL_RELOAD;
        poll_pending <= 1'b1;
      end else begin
        poll_cnt <= poll_cnt - PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gpioemu_bus_master.sv
// Self-checking bench for gpioemu_bus_master: peripheral model, bus/response
// scoreboards and directed host/poll scenarios.
module tb_gpioemu_bus_master;

  localparam int          STROBE_CYC = 4;
  localparam logic [15:0] INT_ADDR   = 16'h0178;
  localparam logic [15:0] INT_CLR    = 16'h017C;
  localparam int          INT_BIT    = 6;
  localparam int          BW         = 49;

  logic        clk;
  logic        n_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        poll_en;
  logic        irq_pulse;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_wr;
  logic [31:0] sdata_rd;

  logic [BW-1:0] exp_bus_q[$];
  logic [31:0]   exp_rsp_q[$];

  int n_checks;
  int n_errors;
  int cyc;
  int irq_cnt;
  int rsp_cnt;
  int last_run;
  int int_raise_n;
  int int_clear_n;
  logic int_flag;

  assign int_flag = (int_raise_n != int_clear_n);

  gpioemu_bus_master #(
    .POLL_PERIOD(50)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .poll_en   (poll_en),
    .irq_pulse (irq_pulse),
    .busy      (busy),
    .dbg_state (dbg_state),
    .saddress  (saddress),
    .srd       (srd),
    .swr       (swr),
    .sdata_wr  (sdata_wr),
    .sdata_rd  (sdata_rd)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a);
    if (a == INT_ADDR)     return int_flag ? (32'd1 << INT_BIT) : 32'h0;
    if (a == 16'h0168)     return 32'h00024000;
    return {16'hA5A5, a};
  endfunction

  task automatic raise_int();
    if (!int_flag) int_raise_n++;
  endtask

  // peripheral model + bus/response/irq monitor, sampled on the falling edge
  task automatic bus_monitor();
    logic prev_srd, prev_swr, prev_busy, in_prog, t_wr;
    logic [15:0] t_addr;
    logic [31:0] t_data;
    logic [BW-1:0] e;
    int low_cnt, run;
    prev_srd = 1'b1; prev_swr = 1'b1; prev_busy = 1'b0; in_prog = 1'b0;
    t_wr = 1'b0; t_addr = '0; t_data = '0; low_cnt = 0; run = 0;
    forever begin
      @(negedge clk);
      if (!n_reset) begin
        in_prog = 1'b0; prev_srd = 1'b1; prev_swr = 1'b1; prev_busy = 1'b0; run = 0;
      end else begin
        if (!srd || !swr) check("strobe_exclusive", 64'(srd | swr), 64'd1);
        if (prev_srd && prev_swr && (!srd || !swr)) begin
          in_prog = 1'b1; t_wr = !swr; t_addr = saddress; t_data = sdata_wr; low_cnt = 1;
          if (!srd) sdata_rd = model_read(saddress);
        end else if (in_prog && srd && swr) begin
          check("strobe_width", 64'(low_cnt), 64'(STROBE_CYC));
          check("hold_addr", 64'(saddress), 64'(t_addr));
          check("bus_txn_expected", 64'(exp_bus_q.size() != 0), 64'd1);
          if (exp_bus_q.size() != 0) begin
            e = exp_bus_q.pop_front();
            check("bus_txn", 64'({t_wr, t_addr, t_data}), 64'(e));
          end
          if (t_wr && t_addr == INT_CLR && t_data[INT_BIT] && int_flag) int_clear_n++;
          in_prog = 1'b0;
        end else if (in_prog) begin
          low_cnt++;
          check("strobe_addr", 64'(saddress), 64'(t_addr));
          check("strobe_data", 64'(sdata_wr), 64'(t_data));
        end
        if (rsp_valid) begin
          rsp_cnt++;
          check("rsp_expected", 64'(exp_rsp_q.size() != 0), 64'd1);
          if (exp_rsp_q.size() != 0) check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rsp_q.pop_front()));
        end
        if (irq_pulse) begin
          irq_cnt++;
          check("irq_first_idle", 64'({busy, prev_busy}), 64'd1);
        end
        if (busy) run++;
        else if (prev_busy) begin
          last_run = run;
          run = 0;
        end
        prev_srd = srd; prev_swr = swr; prev_busy = busy;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while ((exp_bus_q.size() != 0 || exp_rsp_q.size() != 0 || busy) && w < 400) begin
      @(negedge clk);
      w++;
    end
    check(tag, 64'(w < 400), 64'd1);
    @(posedge clk); #1;
  endtask

  // single host command; optional cycle-by-cycle waveform check after accept
  task automatic host_cmd(input logic wr, input logic [15:0] a, input logic [31:0] d,
                          input logic chk_wave);
    logic [8:0] srd_pat, swr_pat, rv_pat;
    logic addr_ok;
    int w;
    exp_bus_q.push_back({wr, a, wr ? d : 32'h0});
    exp_rsp_q.push_back(wr ? 32'h0 : model_read(a));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("accept_timeout", 64'(w < 500), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    addr_ok = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      srd_pat[k] = srd; swr_pat[k] = swr; rv_pat[k] = rsp_valid;
      if (k < 8 && (saddress != a || sdata_wr != (wr ? d : 32'h0))) addr_ok = 1'b0;
    end
    if (chk_wave) begin
      check("wave_addr_stable", 64'(addr_ok), 64'd1);
      check("wave_srd", 64'(srd_pat), wr ? 64'h1FF : 64'h1C3);
      check("wave_swr", 64'(swr_pat), wr ? 64'h1C3 : 64'h1FF);
      check("wave_rsp_valid", 64'(rv_pat), 64'h100);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] b_addr[3];
    logic [31:0] b_data[3];
    logic        b_wr[3];
    int acc[3];
    int idx, w, irq0, rsp0;

    n_checks = 0; n_errors = 0; cyc = 0; irq_cnt = 0; rsp_cnt = 0; last_run = 0;
    int_raise_n = 0; int_clear_n = 0;
    n_reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    poll_en = 1'b0; sdata_rd = '0;
    fork
      bus_monitor();
    join_none

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_saddress", 64'(saddress), 64'h0);
    check("rst_sdata_wr", 64'(sdata_wr), 64'h0);
    check("rst_strobes", 64'({srd, swr}), 64'h3);
    check("rst_rsp", 64'({rsp_valid, rsp_rdata}), 64'h0);
    check("rst_irq", 64'(irq_pulse), 64'h0);
    check("rst_ready_busy", 64'({cmd_ready, busy, dbg_state}), 64'h8);
    n_reset = 1'b1;
    @(posedge clk); #1;

    // 1: write, 2: read
    host_cmd(1'b1, 16'h016C, 32'h0003C000, 1'b1);
    wait_drain("drain_write");
    host_cmd(1'b0, 16'h0168, 32'h0, 1'b1);
    wait_drain("drain_read");

    // 3a: poll with INT set -> read + clear write + irq
    irq0 = irq_cnt; rsp0 = rsp_cnt;
    raise_int();
    exp_bus_q.push_back({1'b0, INT_ADDR, 32'h0});
    exp_bus_q.push_back({1'b1, INT_CLR, 32'h40});
    poll_en = 1'b1;
    w = 0;
    while (irq_cnt == irq0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("poll_irq_timeout", 64'(w < 300), 64'd1);
    @(posedge clk); #1;
    poll_en = 1'b0;
    wait_drain("drain_poll_set");
    check("poll_irq_count", 64'(irq_cnt - irq0), 64'd1);
    check("poll_no_rsp", 64'(rsp_cnt - rsp0), 64'd0);
    check("poll_no_gap", 64'(last_run), 64'd16);
    check("poll_int_cleared", 64'(int_flag), 64'd0);

    // 3b: poll with INT clear -> read only
    irq0 = irq_cnt;
    exp_bus_q.push_back({1'b0, INT_ADDR, 32'h0});
    poll_en = 1'b1;
    w = 0;
    while (exp_bus_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("poll_read_timeout", 64'(w < 300), 64'd1);
    @(posedge clk); #1;
    poll_en = 1'b0;
    wait_drain("drain_poll_clear");
    check("poll_clear_no_irq", 64'(irq_cnt - irq0), 64'd0);
    check("poll_read_only", 64'(last_run), 64'd8);

    // 4: command arrives in the cycle poll_pending is set
    irq0 = irq_cnt;
    raise_int();
    poll_en = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    exp_bus_q.push_back({1'b0, INT_ADDR, 32'h0});
    exp_bus_q.push_back({1'b1, INT_CLR, 32'h40});
    exp_bus_q.push_back({1'b0, 16'h0168, 32'h0});
    exp_rsp_q.push_back(32'h00024000);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0168; cmd_wdata = '0;
    check("arb_ready_low", 64'(cmd_ready), 64'd0);
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("arb_ready_low_cycles", 64'(w), 64'd17);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_drain("drain_arb");
    poll_en = 1'b0;
    check("arb_irq", 64'(irq_cnt - irq0), 64'd1);

    // 5: reset in the middle of a read strobe
    rsp0 = rsp_cnt; irq0 = irq_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0168;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_strobe_active", 64'(srd), 64'd0);
    #1;
    n_reset = 1'b0;
    #1;
    check("rst_async_srd", 64'({srd, swr, busy}), 64'h6);
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    check("rst_rel_ready", 64'(cmd_ready), 64'd1);
    check("rst_rel_bus", 64'({saddress, sdata_wr, srd, swr}), 64'h3);
    check("rst_rel_rsp", 64'({rsp_valid, rsp_rdata, irq_pulse}), 64'h0);
    repeat (12) @(negedge clk);
    check("rst_no_rsp", 64'(rsp_cnt - rsp0), 64'd0);
    check("rst_no_irq", 64'(irq_cnt - irq0), 64'd0);
    @(posedge clk); #1;

    // 6: cmd_valid held for three back-to-back commands
    b_wr[0] = 1'b1; b_addr[0] = 16'h0100; b_data[0] = 32'h11112222;
    b_wr[1] = 1'b0; b_addr[1] = 16'h0104; b_data[1] = 32'h0;
    b_wr[2] = 1'b1; b_addr[2] = 16'h0108; b_data[2] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      exp_bus_q.push_back({b_wr[i], b_addr[i], b_data[i]});
      exp_rsp_q.push_back(b_wr[i] ? 32'h0 : model_read(b_addr[i]));
      acc[i] = 0;
    end
    idx = 0; w = 0;
    cmd_valid = 1'b1; cmd_write = b_wr[0]; cmd_addr = b_addr[0]; cmd_wdata = b_data[0];
    while (idx < 3 && w < 100) begin
      @(negedge clk);
      w++;
      if (cmd_ready) begin
        acc[idx] = cyc;
        idx++;
        @(posedge clk); #1;
        if (idx < 3) begin
          cmd_write = b_wr[idx]; cmd_addr = b_addr[idx]; cmd_wdata = b_data[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    check("b2b_accept_count", 64'(idx), 64'd3);
    check("b2b_gap_01", 64'(acc[1] - acc[0]), 64'd9);
    check("b2b_gap_12", 64'(acc[2] - acc[1]), 64'd9);
    wait_drain("drain_b2b");

    check("final_bus_q_empty", 64'(exp_bus_q.size()), 64'd0);
    check("final_rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);
    check("final_rsp_count", 64'(rsp_cnt), 64'd6);
    check("final_irq_count", 64'(irq_cnt), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
